ysyx_25070198_mem_arb: RTL and testbench
========================================

Name: ysyx_25070198_mem_arb

Overview:
- Shares the single core memory port between the IFU (instruction fetch) and the LSU (load/store).
- Sits between ysyx_25070198_ifu / exu and the memory/bus model.
- Serializes requests with one outstanding transaction at a time.
- Two-way round-robin arbitration; per-transaction response timeout with an error flag.

Parameters:
TIMEOUT_CYC, 255, max cycles waiting for mem_respValid after mem accept; 0 disables timeout
CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYC

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset (rst==0 resets on clk edge)
ifu_reqValid  in  1  IFU fetch request
ifu_reqReady  out  1  arbiter accepts IFU request this cycle
ifu_raddr  in  32  fetch address
ifu_respValid  out  1  one-cycle pulse, fetch data valid
ifu_rdata  out  32  fetch data, held until next IFU response
ifu_err  out  1  qualifies ifu_respValid: 1 = timeout
lsu_reqValid  in  1  LSU request
lsu_reqReady  out  1  arbiter accepts LSU request this cycle
lsu_addr  in  32  byte address; forwarded unmodified
lsu_wen  in  1  1 = store, 0 = load
lsu_wdata  in  32  store data
lsu_wmask  in  4  byte strobes
lsu_respValid  out  1  one-cycle pulse, load data / store ack
lsu_rdata  out  32  load data, held until next LSU response; 0 for stores
lsu_err  out  1  qualifies lsu_respValid: 1 = timeout
mem_reqValid  out  1  downstream request
mem_reqReady  in  1  downstream accepts
mem_addr  out  32  registered address
mem_wen  out  1  registered write enable (0 for IFU)
mem_wdata  out  32  registered write data (0 for IFU)
mem_wmask  out  4  registered mask (0 for IFU)
mem_respValid  in  1  downstream response
mem_rdata  in  32  downstream read data

Behaviour:
- States:
  - IDLE: arbitrate.
  - REQ: mem_reqValid=1, fields stable until mem_reqReady.
  - WAIT: count cycles, await mem_respValid.
  - RESP: one-cycle response pulse to the owner, then IDLE.
- IDLE arbitration (combinational):
  - Only one valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - last_grant resets to IFU, so the first tie goes to LSU.
  - Winner's reqReady=1 in IDLE only; loser's reqReady=0; both 0 in all other states.
- Accept (valid & ready at edge):
  - Latch owner, addr, wen/wdata/wmask (IFU forces wen=0, wdata=0, wmask=0).
  - Update last_grant; go REQ.
- REQ: hold mem_* stable; on mem_reqReady go WAIT, clear counter.
- WAIT:
  - On mem_respValid: capture mem_rdata into the owner's rdata register (LSU store → 0), err=0, go RESP.
  - Else, if TIMEOUT_CYC≠0 and counter==TIMEOUT_CYC-1: owner rdata=0, err=1, go RESP.
  - Else counter+1; counter saturates, never wraps.
- RESP:
  - Owner's respValid=1 for exactly one cycle; err valid with it.
  - Next state IDLE. No new accept in the RESP cycle.
- mem_respValid outside WAIT (late after timeout, or spurious) is ignored; no state or data change.
- Minimum latency, accept at edge N:
  - mem_reqValid visible cycle N+1.
  - mem_reqReady at N+1 → WAIT at N+2.
  - mem_respValid at N+2 → respValid at N+3.
  - Next accept possible at edge N+4.
- Requesters must hold valid and fields until accepted. The arbiter does not register unaccepted requests.
- Reset (rst==0 at edge, including mid-transaction):
  - State IDLE, last_grant=IFU, counter=0.
  - All reqReady/respValid/err=0, all rdata=0, mem_reqValid=0, mem_addr/wdata/wmask/wen=0.
  - An in-flight transaction is abandoned; no response is issued for it.
- ifu_respValid and lsu_respValid are never asserted in the same cycle.

Decomposition:
- Shared package ysyx_25070198_pkg:
  - mem_arb_state_t enum {IDLE, REQ, WAIT, RESP}, 2 bits.
  - req_owner_t {OWN_IFU=0, OWN_LSU=1}.
  - MEM_ADDR_W=32, MEM_DATA_W=32.
- One sub-module: ysyx_25070198_rr_arb2, combinational two-way round-robin grant.
  - Inputs: req[1:0], last_grant.
  - Output: one-hot gnt[1:0].
  - Reused later for a register-file write-port or CSR arbiter.

Test Plan:
- Reset then IFU only: ifu_raddr=0x80000000, mem_reqReady=1, mem_respValid one cycle after mem accept with rdata=0x00000413 → mem_addr=0x80000000, mem_wen=0, ifu_respValid pulse 1 cycle, ifu_rdata=0x00000413, ifu_err=0.
- Tie from reset: both valid same cycle → LSU granted first; IFU granted on the next IDLE; then on a second tie, LSU again (alternation).
- LSU store sb: addr=0x80001003, wdata=0xAB000000, wmask=4'b1000, mem_reqReady low 3 cycles → mem_* held constant through stall; lsu_respValid with lsu_rdata=0, err=0.
- Timeout: TIMEOUT_CYC=4, no mem_respValid → owner respValid with err=1, rdata=0 exactly 4 WAIT cycles after accept; late mem_respValid two cycles later ignored, state stays IDLE.
- Reset in WAIT: rst=0 one edge mid-transaction → all outputs zero next cycle; subsequent mem_respValid produces no response; next IFU request completes normally.
- Back-to-back LSU loads with IFU idle: second accept occurs exactly at edge N+4 under the minimum-latency memory; rdata of each captured correctly.

Source files
------------

// File: rtl/ysyx_25070198_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding, requester
// identity and bus widths.
package ysyx_25070198_pkg;

   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } mem_arb_state_t;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } req_owner_t;

endpackage

// File: rtl/ysyx_25070198_rr_arb2.sv
// Combinational two-way round-robin grant; on a tie the requester that was
// not granted last wins. gnt[0] is the IFU side, gnt[1] the LSU side.
module ysyx_25070198_rr_arb2
   import ysyx_25070198_pkg::*;
(
   input  logic [1:0] req,
   input  req_owner_t last_grant,
   output logic [1:0] gnt
);

   // One-hot grant selection
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_grant == OWN_IFU) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/ysyx_25070198_mem_arb.sv
// Shares the single core memory port between IFU and LSU: round-robin
// arbitration, one outstanding transaction, per-transaction response timeout.
module ysyx_25070198_mem_arb
   import ysyx_25070198_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ifu_reqValid,
   output logic                  ifu_reqReady,
   input  logic [MEM_ADDR_W-1:0] ifu_raddr,
   output logic                  ifu_respValid,
   output logic [MEM_DATA_W-1:0] ifu_rdata,
   output logic                  ifu_err,
   input  logic                  lsu_reqValid,
   output logic                  lsu_reqReady,
   input  logic [MEM_ADDR_W-1:0] lsu_addr,
   input  logic                  lsu_wen,
   input  logic [MEM_DATA_W-1:0] lsu_wdata,
   input  logic [3:0]            lsu_wmask,
   output logic                  lsu_respValid,
   output logic [MEM_DATA_W-1:0] lsu_rdata,
   output logic                  lsu_err,
   output logic                  mem_reqValid,
   input  logic                  mem_reqReady,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic                  mem_wen,
   output logic [MEM_DATA_W-1:0] mem_wdata,
   output logic [3:0]            mem_wmask,
   input  logic                  mem_respValid,
   input  logic [MEM_DATA_W-1:0] mem_rdata
);

   localparam bit             TO_EN   = (TIMEOUT_CYC != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   mem_arb_state_t        state_q, state_d;
   req_owner_t            owner_q, owner_d;
   req_owner_t            last_q, last_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [MEM_ADDR_W-1:0] addr_q, addr_d;
   logic                  wen_q, wen_d;
   logic [MEM_DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]            wmask_q, wmask_d;
   logic [MEM_DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
   logic [MEM_DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
   logic                  err_q, err_d;
   logic [1:0]            gnt_s;
   logic                  idle_s;
   logic                  resp_s;

   ysyx_25070198_rr_arb2 u_rr_arb2 (
      .req        ({lsu_reqValid, ifu_reqValid}),
      .last_grant (last_q),
      .gnt        (gnt_s)
   );

   // Ready is suppressed while reset is asserted so no handshake is seen on a reset edge
   assign idle_s        = rst & (state_q == IDLE);
   assign resp_s        = (state_q == RESP);
   assign ifu_reqReady  = idle_s & gnt_s[0];
   assign lsu_reqReady  = idle_s & gnt_s[1];
   assign ifu_respValid = resp_s & (owner_q == OWN_IFU);
   assign lsu_respValid = resp_s & (owner_q == OWN_LSU);
   assign ifu_err       = ifu_respValid & err_q;
   assign lsu_err       = lsu_respValid & err_q;
   assign ifu_rdata     = ifu_rdata_q;
   assign lsu_rdata     = lsu_rdata_q;
   assign mem_reqValid  = (state_q == REQ);
   assign mem_addr      = addr_q;
   assign mem_wen       = wen_q;
   assign mem_wdata     = wdata_q;
   assign mem_wmask     = wmask_q;

   // Next-state and datapath capture for the transaction FSM
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wen_d       = wen_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;
      ifu_rdata_d = ifu_rdata_q;
      lsu_rdata_d = lsu_rdata_q;
      err_d       = err_q;
      case (state_q)
         IDLE: begin
            if (gnt_s != 2'b00) begin
               owner_d = gnt_s[1] ? OWN_LSU : OWN_IFU;
               last_d  = gnt_s[1] ? OWN_LSU : OWN_IFU;
               addr_d  = gnt_s[1] ? lsu_addr : ifu_raddr;
               wen_d   = gnt_s[1] & lsu_wen;
               wdata_d = gnt_s[1] ? lsu_wdata : {MEM_DATA_W{1'b0}};
               wmask_d = gnt_s[1] ? lsu_wmask : 4'b0000;
               state_d = REQ;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (mem_reqReady) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = WAIT;
            end else begin
               state_d = REQ;
            end
         end
         WAIT: begin
            if (mem_respValid) begin
               if (owner_q == OWN_LSU) begin
                  lsu_rdata_d = wen_q ? {MEM_DATA_W{1'b0}} : mem_rdata;
               end else begin
                  ifu_rdata_d = mem_rdata;
               end
               err_d   = 1'b0;
               state_d = RESP;
            end else if (TO_EN && (cnt_q == TO_LAST)) begin
               if (owner_q == OWN_LSU) begin
                  lsu_rdata_d = {MEM_DATA_W{1'b0}};
               end else begin
                  ifu_rdata_d = {MEM_DATA_W{1'b0}};
               end
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = (cnt_q != CNT_MAX) ? (cnt_q + CNT_W'(1)) : cnt_q;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IFU;
         last_q      <= OWN_IFU;
         cnt_q       <= {CNT_W{1'b0}};
         addr_q      <= {MEM_ADDR_W{1'b0}};
         wen_q       <= 1'b0;
         wdata_q     <= {MEM_DATA_W{1'b0}};
         wmask_q     <= 4'b0000;
         ifu_rdata_q <= {MEM_DATA_W{1'b0}};
         lsu_rdata_q <= {MEM_DATA_W{1'b0}};
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wen_q       <= wen_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
         ifu_rdata_q <= ifu_rdata_d;
         lsu_rdata_q <= lsu_rdata_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_ysyx_25070198_mem_arb.sv
// Directed bench for the IFU/LSU memory arbiter with a transaction-level
// reference model (arbitration order, expected requests, responses, latency).
module tb_ysyx_25070198_mem_arb;

   localparam int TO = 4;

   typedef struct {
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } req_t;

   typedef struct {
      bit          own;
      logic [31:0] rdata;
      bit          err;
      int          lat;
   } resp_t;

   logic        clk, rst;
   logic        ifu_reqValid, ifu_reqReady, ifu_respValid, ifu_err;
   logic [31:0] ifu_raddr, ifu_rdata;
   logic        lsu_reqValid, lsu_reqReady, lsu_wen, lsu_respValid, lsu_err;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [3:0]  lsu_wmask;
   logic        mem_reqValid, mem_reqReady, mem_wen, mem_respValid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // reference model state
   req_t  ifu_pend[$];
   req_t  lsu_pend[$];
   bit    acc_q[$];
   req_t  mreq_q[$];
   resp_t resp_q[$];
   bit    m_last = 1'b0;
   logic [31:0] m_ifu_rdata = 32'h0;
   logic [31:0] m_lsu_rdata = 32'h0;
   int    cur_acc = 0;
   int    last_lat = 0;
   int    n_ifu_resp = 0;
   bit    acc_own[$];
   int    acc_edge[$];

   // memory responder configuration
   bit no_resp = 1'b0;
   int stall_cfg = 0;
   int inj_req = 0;

   ysyx_25070198_mem_arb #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .ifu_reqValid(ifu_reqValid), .ifu_reqReady(ifu_reqReady), .ifu_raddr(ifu_raddr),
      .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
      .lsu_reqValid(lsu_reqValid), .lsu_reqReady(lsu_reqReady), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
      .mem_reqValid(mem_reqValid), .mem_reqReady(mem_reqReady), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_respValid(mem_respValid), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a == 32'h8000_0000) ? 32'h0000_0413 : {a[15:0], ~a[15:0]};
   endfunction

   function automatic req_t mk(input logic [31:0] a, input logic w,
                               input logic [31:0] d, input logic [3:0] m);
      req_t r;
      r.addr = a; r.wen = w; r.wdata = d; r.wmask = m;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory model: accepts after stall_cfg low-ready cycles, answers one cycle after accept
   initial begin
      bit          hs;
      logic [31:0] hs_addr;
      logic        hs_wen;
      int          stall_left;
      int          inj_done;
      mem_reqReady = 1'b0; mem_respValid = 1'b0; mem_rdata = 32'h0;
      stall_left = 0; inj_done = 0;
      forever begin
         @(negedge clk);
         hs = mem_reqValid && mem_reqReady;
         hs_addr = mem_addr;
         hs_wen = mem_wen;
         @(posedge clk);
         #2;
         mem_respValid = 1'b0;
         if (hs && !no_resp) begin
            mem_respValid = 1'b1;
            mem_rdata = hs_wen ? 32'hDEAD_BEEF : mem_fn(hs_addr);
         end else if (inj_req != inj_done) begin
            mem_respValid = 1'b1;
            mem_rdata = 32'h1234_5678;
            inj_done = inj_req;
         end
         if (!mem_reqValid) stall_left = stall_cfg;
         mem_reqReady = (mem_reqValid && stall_left == 0) ? 1'b1 : 1'b0;
         if (mem_reqValid && stall_left > 0) stall_left--;
      end
   end

   // Transaction-level prediction: winner order, mem fields, response and latency
   task automatic predict();
      int    ii, li;
      bit    pick_lsu;
      req_t  r;
      resp_t e;
      ii = 0; li = 0;
      while (ii < ifu_pend.size() || li < lsu_pend.size()) begin
         if (ii < ifu_pend.size() && li < lsu_pend.size()) pick_lsu = (m_last == 1'b0);
         else pick_lsu = (li < lsu_pend.size());
         if (pick_lsu) begin
            r = lsu_pend[li]; li++;
         end else begin
            r = mk(ifu_pend[ii].addr, 1'b0, 32'h0, 4'h0); ii++;
         end
         acc_q.push_back(pick_lsu);
         mreq_q.push_back(r);
         e.own   = pick_lsu;
         e.err   = no_resp;
         e.rdata = (no_resp || r.wen) ? 32'h0 : mem_fn(r.addr);
         e.lat   = 1 + stall_cfg + (no_resp ? TO : 1);
         resp_q.push_back(e);
         m_last = pick_lsu;
      end
   endtask

   task automatic present();
      if (ifu_pend.size() > 0) begin
         ifu_reqValid = 1'b1; ifu_raddr = ifu_pend[0].addr;
      end else begin
         ifu_reqValid = 1'b0;
      end
      if (lsu_pend.size() > 0) begin
         lsu_reqValid = 1'b1; lsu_addr = lsu_pend[0].addr; lsu_wen = lsu_pend[0].wen;
         lsu_wdata = lsu_pend[0].wdata; lsu_wmask = lsu_pend[0].wmask;
      end else begin
         lsu_reqValid = 1'b0;
      end
   endtask

   // Requesters hold valid/fields until accepted, then move to their next entry
   task automatic drive(input int budget, input bit until_done, input string tag);
      bit ai, al, done;
      int n;
      n = 0;
      predict();
      present();
      done = 1'b0;
      while (n < budget && !done) begin
         if (until_done && ifu_pend.size() == 0 && lsu_pend.size() == 0 && resp_q.size() == 0)
            done = 1'b1;
         else begin
            @(negedge clk);
            ai = ifu_reqValid && ifu_reqReady;
            al = lsu_reqValid && lsu_reqReady;
            @(posedge clk);
            #1;
            if (ai) void'(ifu_pend.pop_front());
            if (al) void'(lsu_pend.pop_front());
            present();
            n++;
         end
      end
      if (until_done) chk({"done_", tag}, {31'h0, done}, 32'h1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      ifu_reqValid = 1'b0; lsu_reqValid = 1'b0;
      ifu_pend.delete(); lsu_pend.delete();
      acc_q.delete(); mreq_q.delete(); resp_q.delete();
      m_last = 1'b0; m_ifu_rdata = 32'h0; m_lsu_rdata = 32'h0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ctl"}, {23'h0, ifu_reqReady, lsu_reqReady, ifu_respValid, lsu_respValid,
                          ifu_err, lsu_err, mem_reqValid, mem_wen, mem_wmask != 4'h0}, 32'h0);
      chk({tag, "_ifu_rdata"}, ifu_rdata, 32'h0);
      chk({tag, "_lsu_rdata"}, lsu_rdata, 32'h0);
      chk({tag, "_mem_addr"}, mem_addr, 32'h0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
   endtask

   // Compare process: DUT outputs against the model on every out-of-reset cycle
   initial begin
      resp_t ce;
      req_t  cr;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("resp_exclusive", {31'h0, ifu_respValid & lsu_respValid}, 32'h0);
            chk("ready_exclusive", {31'h0, ifu_reqReady & lsu_reqReady}, 32'h0);
            if (ifu_respValid || lsu_respValid) begin
               chk("resp_expected", {31'h0, resp_q.size() != 0}, 32'h1);
               if (resp_q.size() != 0) begin
                  ce = resp_q.pop_front();
                  chk("resp_owner", {31'h0, lsu_respValid}, {31'h0, ce.own});
                  chk("resp_rdata", lsu_respValid ? lsu_rdata : ifu_rdata, ce.rdata);
                  chk("resp_err", {31'h0, lsu_respValid ? lsu_err : ifu_err}, {31'h0, ce.err});
                  chk("resp_latency", 32'(cyc - cur_acc), 32'(ce.lat));
                  last_lat = cyc - cur_acc;
                  if (lsu_respValid) m_lsu_rdata = ce.rdata;
                  else begin
                     m_ifu_rdata = ce.rdata;
                     n_ifu_resp++;
                  end
               end
            end
            if (!ifu_respValid) begin
               chk("ifu_rdata_hold", ifu_rdata, m_ifu_rdata);
               chk("ifu_err_idle", {31'h0, ifu_err}, 32'h0);
            end
            if (!lsu_respValid) begin
               chk("lsu_rdata_hold", lsu_rdata, m_lsu_rdata);
               chk("lsu_err_idle", {31'h0, lsu_err}, 32'h0);
            end
            if (mem_reqValid) begin
               chk("mem_req_expected", {31'h0, mreq_q.size() != 0}, 32'h1);
               if (mreq_q.size() != 0) begin
                  cr = mreq_q[0];
                  chk("mem_addr", mem_addr, cr.addr);
                  chk("mem_wen", {31'h0, mem_wen}, {31'h0, cr.wen});
                  chk("mem_wdata", mem_wdata, cr.wdata);
                  chk("mem_wmask", {28'h0, mem_wmask}, {28'h0, cr.wmask});
                  if (mem_reqReady) void'(mreq_q.pop_front());
               end
            end
            if ((ifu_reqValid && ifu_reqReady) || (lsu_reqValid && lsu_reqReady)) begin
               chk("grant_owner", {31'h0, lsu_reqValid && lsu_reqReady},
                   acc_q.size() != 0 ? {31'h0, acc_q[0]} : 32'h2);
               if (acc_q.size() != 0) void'(acc_q.pop_front());
               cur_acc = cyc + 1;
               acc_own.push_back(lsu_reqValid && lsu_reqReady);
               acc_edge.push_back(cyc + 1);
            end
         end
      end
   end

   initial begin
      rst = 1'b0;
      ifu_reqValid = 1'b0; ifu_raddr = 32'h0;
      lsu_reqValid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk);
      #1;

      // IFU-only fetch at minimum latency
      ifu_pend.push_back(mk(32'h8000_0000, 1'b0, 32'h0, 4'h0));
      drive(20, 1'b1, "ifu_only");
      chk("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
      chk("t1_mem_addr", mem_addr, 32'h8000_0000);
      chk("t1_mem_wen", {31'h0, mem_wen}, 32'h0);
      chk("t1_resp_count", 32'(n_ifu_resp), 32'd1);
      chk("t1_latency", 32'(last_lat), 32'd2);

      // Ties from reset alternate, LSU first
      do_reset();
      acc_own.delete();
      ifu_pend.push_back(mk(32'h8000_0010, 1'b0, 32'h0, 4'h0));
      ifu_pend.push_back(mk(32'h8000_0014, 1'b0, 32'h0, 4'h0));
      lsu_pend.push_back(mk(32'h8000_0400, 1'b0, 32'h0, 4'hF));
      lsu_pend.push_back(mk(32'h8000_0404, 1'b0, 32'h0, 4'hF));
      drive(60, 1'b1, "tie");
      chk("t2_order", {28'h0, acc_own[0], acc_own[1], acc_own[2], acc_own[3]}, 32'hA);
      chk("t2_lsu_rdata", lsu_rdata, 32'h0404_FBFB);

      // LSU byte store with a three-cycle downstream stall
      stall_cfg = 3;
      lsu_pend.push_back(mk(32'h8000_1003, 1'b1, 32'hAB00_0000, 4'b1000));
      drive(30, 1'b1, "store");
      stall_cfg = 0;
      chk("t3_lsu_rdata", lsu_rdata, 32'h0);
      chk("t3_mem_wmask", {28'h0, mem_wmask}, 32'h8);
      chk("t3_mem_wdata", mem_wdata, 32'hAB00_0000);
      chk("t3_latency", 32'(last_lat), 32'd5);

      // Timeout with a late response that must be ignored
      no_resp = 1'b1;
      ifu_pend.push_back(mk(32'h8000_0300, 1'b0, 32'h0, 4'h0));
      drive(30, 1'b1, "timeout");
      chk("t4_ifu_rdata", ifu_rdata, 32'h0);
      chk("t4_latency", 32'(last_lat), 32'd5);
      inj_req++;
      repeat (3) @(posedge clk);
      #1;
      no_resp = 1'b0;
      chk("t4_idle_after_late", {31'h0, mem_reqValid}, 32'h0);

      // Reset while waiting for the response
      no_resp = 1'b1;
      ifu_pend.push_back(mk(32'h8000_0100, 1'b0, 32'h0, 4'h0));
      drive(4, 1'b0, "wait_rst");
      do_reset();
      @(negedge clk);
      chk_reset_outputs("mid_reset");
      @(posedge clk);
      #1;
      inj_req++;
      repeat (4) @(posedge clk);
      #1;
      no_resp = 1'b0;
      ifu_pend.push_back(mk(32'h8000_0000, 1'b0, 32'h0, 4'h0));
      drive(20, 1'b1, "after_reset");
      chk("t5_ifu_rdata", ifu_rdata, 32'h0000_0413);

      // Back-to-back LSU loads at minimum latency
      acc_edge.delete();
      lsu_pend.push_back(mk(32'h8000_0200, 1'b0, 32'h0, 4'hF));
      lsu_pend.push_back(mk(32'h8000_0204, 1'b0, 32'h0, 4'hF));
      drive(30, 1'b1, "b2b");
      chk("t6_accept_spacing", 32'(acc_edge[1] - acc_edge[0]), 32'd4);
      chk("t6_lsu_rdata", lsu_rdata, 32'h0204_FDFB);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
